// File: rtl/mantis_addsub_norm.sv
// -----------------------------------------------------------------------------
// mantis_addsub_norm
//
// Purpose:
//   Effective add/subtract of two exponent-aligned mantissas followed by
//   normalisation. The result (sign, exponent, mantissa, flags) goes to the
//   rounding stage over a valid/ready handshake.
//   Mantissa layout: [27] carry, [26] hidden one, [25:3] fraction,
//   [2:0] guard/round/sticky.
//
//   Default build: normalisation is iterative, one left shift per cycle.
//   Define NORM_FAST_EN to normalise in a single cycle instead. That path
//   uses a leading-one encoder and a barrel shift, clamped so the results
//   match the iterative path.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand pair handshake (in_ready = state IDLE)
//   op_sub               1 = A-B, 0 = A+B
//   sign_a, sign_b       operand signs
//   exp_in               common aligned exponent
//   mantis_a, mantis_b   aligned mantissas (bit 27 is zero)
//   out_valid/out_ready  result handshake (out_valid = state DONE)
//   sign_out, exp_out    result sign and exponent
//   mantis_out           normalised mantissa
//   zero                 result is exactly zero
//   overflow             exponent saturated to all-ones, mantissa forced to 0
//   underflow            result is denormal (exponent 0)
//   busy                 state is not IDLE
// -----------------------------------------------------------------------------
module mantis_addsub_norm #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mantis_a,
    input  logic [MANT_W-1:0] mantis_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mantis_out,
    output logic              zero,
    output logic              overflow,
    output logic              underflow,
    output logic              busy
);

    localparam int                 CARRY_BIT = MANT_W - 1;
    localparam int                 HIDDEN    = MANT_W - 2;
    localparam logic [EXP_W-1:0]   EXP_MAX   = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                out_valid_q;

    logic                op_sub_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic [MANT_W-1:0]   a_q;
    logic [MANT_W-1:0]   b_q;
    logic [MANT_W-1:0]   m_q;
    logic [EXP_W-1:0]    exp_q;
    logic                sign_q;
    logic                zero_q;
    logic                overflow_q;
    logic                underflow_q;

    // ------------------------------------------------------------------
    // Add/subtract datapath (consumed in ADD)
    // ------------------------------------------------------------------
    logic                eff_sub_d;
    logic [MANT_W-1:0]   sum_m_d;
    logic                sum_sign_d;

    always_comb begin
        eff_sub_d  = op_sub_q ^ sign_a_q ^ sign_b_q;
        sum_m_d    = '0;
        sum_sign_d = 1'b0;
        if (!eff_sub_d) begin
            // Both inputs have bit 27 clear, so the sum cannot lose a carry.
            sum_m_d    = a_q + b_q;
            sum_sign_d = sign_a_q;
        end else if (a_q == b_q) begin
            // Exact cancellation always yields +0.
            sum_m_d    = '0;
            sum_sign_d = 1'b0;
        end else if (a_q > b_q) begin
            sum_m_d    = a_q - b_q;
            sum_sign_d = sign_a_q;
        end else begin
            sum_m_d    = b_q - a_q;
            sum_sign_d = sign_b_q ^ op_sub_q;
        end
    end

    // Right shift by one after a carry-out; the two lowest bits fold into
    // the sticky position so no set bit is lost.
    logic [MANT_W-1:0]   rshift_m_d;
    logic [EXP_W-1:0]    exp_inc_d;

    always_comb begin
        rshift_m_d = {1'b0, m_q[MANT_W-1:2], m_q[1] | m_q[0]};
        exp_inc_d  = exp_q + 1'b1;
    end

`ifdef NORM_FAST_EN
    // ------------------------------------------------------------------
    // Single-cycle left normalisation. Only used when bits 27 and 26 are
    // both clear and m is non-zero, so the leading one lies below HIDDEN.
    // ------------------------------------------------------------------
    localparam int SH_W = $clog2(MANT_W);

    logic [SH_W-1:0]     lead_pos_d;
    logic [SH_W-1:0]     shift_need_d;
    logic [EXP_W-1:0]    exp_room_d;
    logic                clamp_d;
    logic [SH_W-1:0]     shift_amt_d;
    logic [MANT_W-1:0]   fast_m_d;
    logic [EXP_W-1:0]    fast_exp_d;

    always_comb begin
        lead_pos_d = '0;
        for (int i = 0; i < HIDDEN; i++) begin
            if (m_q[i]) begin
                lead_pos_d = SH_W'(i);
            end
        end
        shift_need_d = SH_W'(HIDDEN) - lead_pos_d;
        // The iterative path stops shifting once the exponent reaches 1.
        // An exponent of 0 therefore allows no shift at all.
        exp_room_d   = (exp_q == '0) ? '0 : exp_q - 1'b1;
        clamp_d      = (int'(shift_need_d) > int'(exp_room_d));
        // When clamped, exp_room_d < shift_need_d, so it fits in SH_W bits.
        shift_amt_d  = clamp_d ? exp_room_d[SH_W-1:0] : shift_need_d;
        fast_m_d     = m_q << shift_amt_d;
        fast_exp_d   = clamp_d ? '0 : exp_q - EXP_W'(shift_need_d);
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM and all state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            op_sub_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_sub_q    <= op_sub;
                        sign_a_q    <= sign_a;
                        sign_b_q    <= sign_b;
                        a_q         <= mantis_a;
                        b_q         <= mantis_b;
                        exp_q       <= exp_in;
                        zero_q      <= 1'b0;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        state_q     <= ADD;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end

                ADD: begin
                    m_q     <= sum_m_d;
                    sign_q  <= sum_sign_d;
                    state_q <= NORM;
                end

                NORM: begin
                    // Most branches finish here; only the shift branch stays.
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    if (m_q == '0) begin
                        zero_q <= 1'b1;
                        exp_q  <= '0;
                        sign_q <= 1'b0;
                    end else if (m_q[CARRY_BIT]) begin
                        exp_q <= exp_inc_d;
                        if (exp_inc_d == EXP_MAX) begin
                            overflow_q <= 1'b1;
                            m_q        <= '0;
                        end else begin
                            m_q <= rshift_m_d;
                        end
                    end else if (m_q[HIDDEN]) begin
                        // Already normal: the result is unchanged.
                    end else begin
`ifdef NORM_FAST_EN
                        m_q         <= fast_m_d;
                        exp_q       <= fast_exp_d;
                        underflow_q <= clamp_d;
`else
                        if (exp_q <= EXP_W'(1)) begin
                            exp_q       <= '0;
                            underflow_q <= 1'b1;
                        end else begin
                            m_q         <= m_q << 1;
                            exp_q       <= exp_q - 1'b1;
                            state_q     <= NORM;
                            out_valid_q <= 1'b0;
                        end
`endif
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign sign_out   = sign_q;
    assign exp_out    = exp_q;
    assign mantis_out = m_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_mantis_addsub_norm.sv
// -----------------------------------------------------------------------------
// tb_mantis_addsub_norm
//
// Directed bench for mantis_addsub_norm. Each scenario task drives its own
// operands and compares outputs against hand-computed values. Latencies are
// counted in clock edges after the acceptance edge. Build with NORM_FAST_EN
// defined to check the single-cycle normaliser variant.
// -----------------------------------------------------------------------------
module tb_mantis_addsub_norm;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;
`ifdef NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mantis_a;
    logic [MANT_W-1:0] mantis_b;
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_out;
    logic [MANT_W-1:0] mantis_out;
    logic              zero;
    logic              overflow;
    logic              underflow;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mantis_addsub_norm #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sub     (op_sub),
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .exp_in     (exp_in),
        .mantis_a   (mantis_a),
        .mantis_b   (mantis_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_out   (sign_out),
        .exp_out    (exp_out),
        .mantis_out (mantis_out),
        .zero       (zero),
        .overflow   (overflow),
        .underflow  (underflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair and count edges after acceptance until
    // out_valid is seen (-1 if it never arrives within the budget).
    task automatic run_op(input logic sub, input logic sa, input logic sb,
                          input logic [EXP_W-1:0] e,
                          input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                          output int lat);
        @(negedge clk);
        op_sub   = sub;
        sign_a   = sa;
        sign_b   = sb;
        exp_in   = e;
        mantis_a = a;
        mantis_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        $display("op sub=%0b sa=%0b sb=%0b exp_in=%0d a=%h b=%h -> lat=%0d sign=%0b exp=%0d mant=%h z=%0b ov=%0b uf=%0b",
                 sub, sa, sb, e, a, b, lat, sign_out, exp_out, mantis_out, zero, overflow, underflow);
    endtask

    // Accept the result with a one-cycle out_ready pulse.
    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%0b required=0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy actual=%0b required=0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready actual=%0b required=1", in_ready); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h0) $display("FAIL reset_mant actual=%h required=0", mantis_out); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        run_op(1'b0, 1'b0, 1'b0, 8'd127, 28'h4000000, 28'h4000000, lat);
        total_cnt++; if (lat !== 2) $display("FAIL add_latency actual=%0d required=2", lat); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h4000000) $display("FAIL add_mant actual=%h required=4000000", mantis_out); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd128) $display("FAIL add_exp actual=%0d required=128", exp_out); else pass_cnt++;
        total_cnt++; if (sign_out !== 1'b0) $display("FAIL add_sign actual=%0b required=0", sign_out); else pass_cnt++;
        total_cnt++; if ({zero, overflow, underflow} !== 3'b000) $display("FAIL add_flags actual=%b required=000", {zero, overflow, underflow}); else pass_cnt++;
        release_result();
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL add_release actual=%0b%0b required=10", in_ready, out_valid); else pass_cnt++;
    endtask

    task automatic test_sub_shift();
        int lat;
        int exp_lat;
        exp_lat = FAST ? 2 : 4;
        // 1.0 - 0.75 = 0.25 -> two left shifts
        run_op(1'b1, 1'b0, 1'b0, 8'd127, 28'h4000000, 28'h3000000, lat);
        total_cnt++; if (lat !== exp_lat) $display("FAIL sub_latency actual=%0d required=%0d", lat, exp_lat); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h4000000) $display("FAIL sub_mant actual=%h required=4000000", mantis_out); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd125) $display("FAIL sub_exp actual=%0d required=125", exp_out); else pass_cnt++;
        total_cnt++; if (sign_out !== 1'b0) $display("FAIL sub_sign actual=%0b required=0", sign_out); else pass_cnt++;
        release_result();
        // 0.75 - 1.0 = -0.25: B is larger, sign = sign_b ^ op_sub = 1
        run_op(1'b1, 1'b0, 1'b0, 8'd127, 28'h3000000, 28'h4000000, lat);
        total_cnt++; if (mantis_out !== 28'h4000000) $display("FAIL subneg_mant actual=%h required=4000000", mantis_out); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd125) $display("FAIL subneg_exp actual=%0d required=125", exp_out); else pass_cnt++;
        total_cnt++; if (sign_out !== 1'b1) $display("FAIL subneg_sign actual=%0b required=1", sign_out); else pass_cnt++;
        release_result();
    endtask

    task automatic test_cancel();
        int lat;
        // (-a) - (-b) with a == b is an effective subtract that cancels exactly
        run_op(1'b1, 1'b1, 1'b1, 8'd127, 28'h5000000, 28'h5000000, lat);
        total_cnt++; if (lat !== 2) $display("FAIL cancel_latency actual=%0d required=2", lat); else pass_cnt++;
        total_cnt++; if (zero !== 1'b1) $display("FAIL cancel_zero actual=%0b required=1", zero); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd0) $display("FAIL cancel_exp actual=%0d required=0", exp_out); else pass_cnt++;
        total_cnt++; if (sign_out !== 1'b0) $display("FAIL cancel_sign actual=%0b required=0", sign_out); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h0) $display("FAIL cancel_mant actual=%h required=0", mantis_out); else pass_cnt++;
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(1'b0, 1'b0, 1'b0, 8'd254, 28'h4000000, 28'h4000000, lat);
        total_cnt++; if (lat !== 2) $display("FAIL ovf_latency actual=%0d required=2", lat); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd255) $display("FAIL ovf_exp actual=%0d required=255", exp_out); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h0) $display("FAIL ovf_mant actual=%h required=0", mantis_out); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag actual=%0b required=1", overflow); else pass_cnt++;
        total_cnt++; if (zero !== 1'b0) $display("FAIL ovf_zero actual=%0b required=0", zero); else pass_cnt++;
        release_result();
    endtask

    task automatic test_underflow();
        int lat;
        int exp_lat;
        exp_lat = FAST ? 2 : 3;
        run_op(1'b1, 1'b0, 1'b0, 8'd2, 28'h4000000, 28'h3000000, lat);
        total_cnt++; if (lat !== exp_lat) $display("FAIL uf_latency actual=%0d required=%0d", lat, exp_lat); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd0) $display("FAIL uf_exp actual=%0d required=0", exp_out); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h2000000) $display("FAIL uf_mant actual=%h required=2000000", mantis_out); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b1) $display("FAIL uf_flag actual=%0b required=1", underflow); else pass_cnt++;
        // overflow from the previous operation must have been cleared on accept
        total_cnt++; if (overflow !== 1'b0) $display("FAIL uf_ovf_cleared actual=%0b required=0", overflow); else pass_cnt++;
        release_result();
    endtask

    task automatic test_hold();
        int lat;
        run_op(1'b0, 1'b0, 1'b0, 8'd127, 28'h4000000, 28'h4000000, lat);
        // A new pair offered while DONE must be ignored.
        in_valid = 1'b1;
        exp_in   = 8'd10;
        mantis_a = 28'h1234567;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold_hs_%0d actual=%0b%0b required=10", i, out_valid, in_ready); else pass_cnt++;
            total_cnt++; if (mantis_out !== 28'h4000000 || exp_out !== 8'd128) $display("FAIL hold_data_%0d actual=%h/%0d required=4000000/128", i, mantis_out, exp_out); else pass_cnt++;
        end
        in_valid = 1'b0;
        release_result();
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL hold_release actual=%0b%0b required=10", in_ready, busy); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        op_sub   = 1'b1;
        sign_a   = 1'b0;
        sign_b   = 1'b0;
        exp_in   = 8'd127;
        mantis_a = 28'h4000000;
        mantis_b = 28'h3000000;
        in_valid = 1'b1;
        @(posedge clk);          // accept
        #1;
        in_valid = 1'b0;
        @(posedge clk);          // ADD -> NORM
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL areset_busy_before actual=%0b required=1", busy); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;                      // no clock edge since rst rose
        $display("async reset mid-NORM -> out_valid=%0b busy=%0b in_ready=%0b", out_valid, busy, in_ready);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid actual=%0b required=0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy actual=%0b required=0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready actual=%0b required=1", in_ready); else pass_cnt++;
        total_cnt++; if (exp_out !== 8'd0 || mantis_out !== 28'h0) $display("FAIL areset_data actual=%0d/%h required=0/0", exp_out, mantis_out); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_after_reset();
        int lat;
        int exp_lat;
        exp_lat = FAST ? 2 : 4;
        run_op(1'b1, 1'b0, 1'b0, 8'd127, 28'h4000000, 28'h3000000, lat);
        total_cnt++; if (lat !== exp_lat) $display("FAIL post_latency actual=%0d required=%0d", lat, exp_lat); else pass_cnt++;
        total_cnt++; if (mantis_out !== 28'h4000000 || exp_out !== 8'd125) $display("FAIL post_result actual=%h/%0d required=4000000/125", mantis_out, exp_out); else pass_cnt++;
        release_result();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_sub    = 1'b0;
        sign_a    = 1'b0;
        sign_b    = 1'b0;
        exp_in    = '0;
        mantis_a  = '0;
        mantis_b  = '0;

        test_reset();
        test_add();
        test_sub_shift();
        test_cancel();
        test_overflow();
        test_underflow();
        test_hold();
        test_async_reset();
        test_after_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mantis_addsub_norm.md
Name: mantis_addsub_norm

Overview:
- Sits directly downstream of the alignment shifter in the preadder path.
- Accepts two operands already aligned to a common 8-bit exponent, each with a 28-bit extended mantissa, and performs an effective add or subtract.
- Normalises the result and presents sign, exponent and mantissa to the rounding stage over a valid/ready handshake.
- Normalisation is iterative: one shift per cycle.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 28, extended mantissa width. Bit layout: [27] carry, [26] hidden one, [25:3] fraction, [2:0] guard/round/sticky.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- op_sub  in  1  1 = A-B, 0 = A+B.
- sign_a  in  1  sign of A.
- sign_b  in  1  sign of B.
- exp_in  in  EXP_W  common aligned exponent.
- mantis_a  in  MANT_W  aligned mantissa of A; bit27 is 0.
- mantis_b  in  MANT_W  aligned mantissa of B; bit27 is 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sign_out  out  1  result sign.
- exp_out  out  EXP_W  result exponent.
- mantis_out  out  MANT_W  normalised mantissa.
- zero  out  1  result is exactly zero.
- overflow  out  1  exponent saturated to 255.
- underflow  out  1  result is denormal (exponent 0).
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: the single clock is clk; rst is asynchronous and active-high. Asserting rst (including mid-operation) forces state IDLE and clears every output register to 0, so out_valid=0, busy=0, in_ready=1. Any in-flight operation is discarded.
- FSM states: IDLE, ADD, NORM, DONE.
  - in_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid&in_ready, register all inputs and go to ADD.
- ADD (1 cycle):
  - eff_sub = op_sub ^ sign_a ^ sign_b.
  - If eff_sub=0: m = a+b, sign = sign_a.
  - If eff_sub=1 and a>=b: m = a-b, sign = sign_a.
  - If eff_sub=1 and a<b: m = b-a, sign = sign_b^op_sub.
  - If eff_sub=1 and a==b: result is +0, sign = 0.
  - exp = exp_in. Next state is NORM.
- NORM, evaluated in priority order each cycle:
  1. m==0: set zero=1, exp=0, sign=0, go to DONE.
  2. m[27]=1: m = {1'b0, m[27:2], m[1]|m[0]} (sticky preserved), exp+1. If the new exp==255, set overflow=1 and m=0. Go to DONE.
  3. m[26]=1: go to DONE unchanged.
  4. exp<=1: set exp=0, underflow=1, go to DONE with m unshifted.
  5. Otherwise: m = m<<1, exp-1, stay in NORM.
- DONE: hold all outputs stable while out_ready=0. On out_ready, go to IDLE; flags clear when the next operand pair is accepted.
- Latency: acceptance edge T, then out_valid is high after edge T+2+k, where k is the number of shift cycles. The k=0 case covers zero, already-normal, right-shift and underflow exits.
- exp_in==255 (inf/NaN) is not handled here; upstream bypasses it.
- No new operand is accepted while busy; there are no simultaneous accept/output cycles.

Optional Feature:
- NORM_FAST_EN defined:
  - NORM completes in exactly one cycle using a leading-one priority encoder and a barrel shift.
  - The left shift is clamped to exp-1, with underflow if clamped.
  - Results are identical to the iterative path; latency is fixed at 3 (out_valid after edge T+2).
- Not defined: the iterative behaviour above.

Test Plan:
1. Add 1.0+1.0: exp_in=127, a=b=28'h4000000, op_sub=0 → mantis_out=28'h4000000, exp_out=128, sign 0, out_valid after edge T+2.
2. Sub 1.0-0.75: exp_in=127, a=28'h4000000, b=28'h3000000, op_sub=1 → two left shifts, mantis_out=28'h4000000, exp_out=125, out_valid after edge T+4 (T+2 with NORM_FAST_EN).
3. Cancellation: a=b=28'h5000000, op_sub=1, sign_a=1 → zero=1, exp_out=0, sign_out=0, mantis_out=0.
4. Overflow: exp_in=254, a=b=28'h4000000, add → exp_out=255, mantis_out=0, overflow=1.
5. Underflow: exp_in=2, a=28'h4000000, b=28'h3000000, sub → after one shift exp=1, then exp_out=0, mantis_out=28'h2000000, underflow=1.
6. Control:
   - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
   - Assert rst during NORM of test 2 → out_valid=0, busy=0, in_ready=1 immediately (asynchronous).
   - A following operation completes correctly.
